// File: rtl/therm_dac_seq.sv
// therm_dac_seq: thermometer-coded DAC level sequencer (ramp, sawtooth, triangle, hold)
module therm_dac_seq #(
    parameter int NBITS   = 4,
    parameter int DWELL_W = 4,
    localparam int LW     = $clog2(NBITS + 1)
) (
    input  logic               dac_clk,
    input  logic               dac_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [LW-1:0]      hold_level,
    output logic [NBITS-1:0]   b,
    output logic [LW-1:0]      level,
    output logic               busy,
    output logic               step,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

    localparam logic [LW-1:0] MAXL = LW'(NBITS);

    state_t             state_q, state_d;
    logic [LW-1:0]      level_q, level_d;
    logic [NBITS-1:0]   b_q, b_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [LW-1:0]      hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    logic               expired;
    logic [LW-1:0]      next_up, next_dn;

    assign expired = cnt_q == dwell_q;
    assign next_up = level_q + 1'b1;
    assign next_dn = level_q - 1'b1;

    assign b     = b_q;
    assign level = level_q;
    assign busy  = busy_q;
    assign step  = step_q;
    assign done  = done_q;

    // State and output registers; reset wins over every other input
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state_q <= IDLE;
            level_q <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            dwell_q <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; the registered outputs are computed from the next level
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    mode_d  = mode;
                    dwell_d = dwell;
                    hold_d  = hold_level > MAXL ? MAXL : hold_level;
                    busy_d  = 1'b1;
                    level_d = '0;
                    cnt_d   = '0;
                    state_d = mode == 2'b11 ? HOLD : UP;
                end
            end
            UP: begin
                if (!expired) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (level_q == MAXL) begin
                        level_d = '0;
                        if (mode_q == 2'b00) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            step_d = 1'b1;
                        end
                    end else begin
                        level_d = next_up;
                        step_d  = 1'b1;
                        state_d = (mode_q == 2'b10 && next_up == MAXL) ? DOWN : UP;
                    end
                end
            end
            DOWN: begin
                if (!expired) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    level_d = next_dn;
                    step_d  = 1'b1;
                    state_d = next_dn == '0 ? UP : DOWN;
                end
            end
            HOLD: begin
                if (level_q != hold_q) begin
                    level_d = hold_q;
                    step_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides whatever the running sequence wanted to do
        if (busy_q && stop) begin
            state_d = IDLE;
            level_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            step_d  = 1'b0;
            done_d  = 1'b1;
        end
        b_d = ~({NBITS{1'b1}} << level_d);
    end

endmodule

// File: doc/therm_dac_seq.md
THERM_DAC_SEQ -- requirements
Module: therm_dac_seq

Interface
REQ-001 SHALL have parameter NBITS, default 4, meaning thermometer output width and maximum level (legal range 2..32).
REQ-002 SHALL have parameter DWELL_W, default 4, meaning width of the per-step dwell setting.
REQ-003 SHALL define LW = clog2(NBITS+1) as a local width for level values.
REQ-004 SHALL have port dac_clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port dac_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  launch a sequence; honoured only when busy=0.
REQ-007 SHALL have port stop  input  1  abort the running sequence.
REQ-008 SHALL have port mode  input  2  sequence mode: 00 single ramp, 01 sawtooth, 10 triangle, 11 hold.
REQ-009 SHALL have port dwell  input  DWELL_W  cycles per level minus one.
REQ-010 SHALL have port hold_level  input  LW  target level for hold mode.
REQ-011 SHALL have port b  output  NBITS  thermometer code: b[i]=1 iff i < level.
REQ-012 SHALL have port level  output  LW  current level, 0..NBITS.
REQ-013 SHALL have port busy  output  1  sequence active.
REQ-014 SHALL have port step  output  1  one-cycle pulse, coincident with each counted level change.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sequence end or abort.

Function
REQ-016 SHALL implement states IDLE, UP, DOWN, HOLD; all outputs registered.
REQ-017 SHALL, in IDLE with start=1 and stop=0 at edge T, latch mode/dwell/hold_level, set busy=1, level=0, and dwell counter=0 at edge T; latched values SHALL then remain fixed until return to IDLE.
REQ-018 SHALL hold each level for exactly dwell+1 cycles before the next step; dwell=0 gives one step per cycle.
REQ-019 SHALL, in mode 00, step 0,1,...,NBITS; after NBITS has dwelled for dwell+1 cycles, SHALL set level=0 and busy=0, pulse done, and enter IDLE.
REQ-020 SHALL, in mode 01, wrap from NBITS to 0 (with a step pulse) and repeat until stop.
REQ-021 SHALL, in mode 10, ping-pong 0..NBITS..0 without repeating endpoints (…,NBITS-1,NBITS,NBITS-1,…,1,0,1,…) until stop; UP→DOWN on reaching NBITS, DOWN→UP on reaching 0.
REQ-022 SHALL, in mode 11, move level directly to min(hold_level, NBITS) one cycle after start (single step pulse, none if the target is 0) and hold it until stop.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on stop=1 while busy=1, set level=0 and busy=0 at the next edge, pulse done, and enter IDLE; no step pulse.
REQ-025 SHALL give stop priority over start when both are asserted in IDLE: remain IDLE, no done.
REQ-026 SHALL keep done=0 when stop is asserted in IDLE.
REQ-027 SHALL keep b consistent with level every cycle (popcount(b)=level, ones contiguous from bit 0).
REQ-028 SHALL never drive level outside 0..NBITS; arithmetic SHALL NOT wrap at 2^LW.
REQ-029 SHALL never assert step and done in the same cycle.

Reset
REQ-030 SHALL, on dac_rst=1 at any edge including mid-sequence, set state=IDLE, level=0, b=0, busy=0, step=0, done=0, and clear the dwell counter and latched settings.
REQ-031 SHALL give dac_rst priority over start and stop.
REQ-032 SHALL accept start on the first edge after dac_rst deasserts.

Verification (NBITS=4, DWELL_W=4)
REQ-033 SHALL verify: mode=00, dwell=0, start pulse at edge T -> level 0,1,2,3,4 at edges T..T+4, b=0000,0001,0011,0111,1111; at T+5 level=0, busy=0, done=1 for one cycle; step=1 at T+1..T+4 only.
REQ-034 SHALL verify: mode=10, dwell=1 -> each level held 2 cycles; sequence 0,1,2,3,4,3,2,1,0,1…; a start pulse mid-run changes nothing.
REQ-035 SHALL verify: mode=01, dwell=2 -> each level held 3 cycles; 4→0 wrap produces a step pulse; stop after the second wrap -> level=0, done=1 on the next edge, busy=0.
REQ-036 SHALL verify: mode=11, hold_level=7 -> level=4, b=1111 one cycle after start and held 20 cycles; hold_level=0 -> level stays 0 with no step.
REQ-037 SHALL verify: dac_rst=1 asserted while level=3 in mode 00 -> all outputs 0 at the next edge, no done pulse; start and stop asserted together in IDLE -> stays IDLE.
REQ-038 SHALL verify, for every cycle of every scenario, that popcount(b)=level, b is contiguous ones from bit 0, and step and done are never high together.
